// File: rtl/lcd_write_arbiter_pkg.sv
// Shared definitions for the two-requester HD44780-style 4-bit LCD write arbiter.
//   lcd_state_t      : transfer FSM state encoding
//   DEF_*_CYC        : default timing constants (50 MHz clock)
//   cnt_width()      : phase counter width (never below 17 bits)
//   max_cyc()        : largest of the timing parameters
//   needs_long_wait(): clear/home command detection
package lcd_write_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP_HI,
    PULSE_HI,
    HOLD_HI,
    SETUP_LO,
    PULSE_LO,
    HOLD_LO,
    WAIT
  } lcd_state_t;

  localparam int unsigned DEF_SETUP_CYC     = 3;
  localparam int unsigned DEF_PULSE_CYC     = 13;
  localparam int unsigned DEF_HOLD_CYC      = 3;
  localparam int unsigned DEF_CMD_WAIT_CYC  = 2000;
  localparam int unsigned DEF_LONG_WAIT_CYC = 82000;
  localparam int unsigned MIN_CNT_W         = 17;

  function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d,
                                          input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = $clog2(max_count + 1);
    return (w < MIN_CNT_W) ? MIN_CNT_W : w;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
  function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Phase timer for the LCD write FSM.
//   clk, rst : clock, asynchronous active-high reset
//   load     : restart the phase (counter back to 0)
//   limit    : length of the current phase in cycles (>= 1)
//   done     : high in the last cycle of the phase
module lcd_phase_timer #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == (limit - CNT_W'(1)));

endmodule

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter for two byte writers sharing one 4-bit LCD bus.
// Each accepted byte goes out as high nibble then low nibble, each with
// setup / E pulse / hold phases, followed by a settle wait.
//   Clock, Reset              : clock, asynchronous active-high reset
//   iReqNValid/Rs/Data        : requester N offers a byte (Rs 0=cmd, 1=data)
//   oReqNReady                : byte from requester N accepted this cycle
//   oLcdRs, oLcdRw, oLcdE     : LCD control pins (Rw tied low)
//   oLcdData                  : LCD D7..D4
//   oBusy                     : transfer in progress
module lcd_write_arbiter
  import lcd_write_arbiter_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC     = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC      = DEF_HOLD_CYC,
  parameter int unsigned CMD_WAIT_CYC  = DEF_CMD_WAIT_CYC,
  parameter int unsigned LONG_WAIT_CYC = DEF_LONG_WAIT_CYC
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iReq0Valid,
  input  logic       iReq0Rs,
  input  logic [7:0] iReq0Data,
  input  logic       iReq1Valid,
  input  logic       iReq1Rs,
  input  logic [7:0] iReq1Data,
  output logic       oReq0Ready,
  output logic       oReq1Ready,
  output logic       oLcdRs,
  output logic       oLcdRw,
  output logic       oLcdE,
  output logic [3:0] oLcdData,
  output logic       oBusy
);

  localparam int unsigned CNT_W =
    cnt_width(max_cyc(SETUP_CYC, PULSE_CYC, HOLD_CYC, CMD_WAIT_CYC, LONG_WAIT_CYC));

  lcd_state_t       state, state_next;
  logic [7:0]       data_q;
  logic             rs_q;
  logic             prefer1_q;   // 1: requester 1 wins a tie
  logic             grant0, grant1;
  logic             idle;
  logic             accept;
  logic             phase_done;
  logic             phase_load;
  logic [CNT_W-1:0] phase_len;

  // Arbitration
  assign idle   = (state == IDLE) && !Reset;
  assign grant0 = iReq0Valid && (!iReq1Valid || !prefer1_q);
  assign grant1 = iReq1Valid && (!iReq0Valid ||  prefer1_q);

  assign oReq0Ready = idle && grant0;
  assign oReq1Ready = idle && grant1;
  assign accept     = oReq0Ready || oReq1Ready;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      data_q    <= '0;
      rs_q      <= 1'b0;
      prefer1_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        data_q    <= oReq0Ready ? iReq0Data : iReq1Data;
        rs_q      <= oReq0Ready ? iReq0Rs   : iReq1Rs;
        prefer1_q <= oReq0Ready;
      end
    end
  end

  // Phase length for the current state
  always_comb begin
    phase_len = CNT_W'(1);
    unique case (state)
      SETUP_HI, SETUP_LO: phase_len = CNT_W'(SETUP_CYC);
      PULSE_HI, PULSE_LO: phase_len = CNT_W'(PULSE_CYC);
      HOLD_HI,  HOLD_LO:  phase_len = CNT_W'(HOLD_CYC);
      WAIT:               phase_len = needs_long_wait(rs_q, data_q) ?
                                      CNT_W'(LONG_WAIT_CYC) : CNT_W'(CMD_WAIT_CYC);
      default:            phase_len = CNT_W'(1);
    endcase
  end

  // Next state
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (accept)     state_next = SETUP_HI;
      SETUP_HI: if (phase_done) state_next = PULSE_HI;
      PULSE_HI: if (phase_done) state_next = HOLD_HI;
      HOLD_HI:  if (phase_done) state_next = SETUP_LO;
      SETUP_LO: if (phase_done) state_next = PULSE_LO;
      PULSE_LO: if (phase_done) state_next = HOLD_LO;
      HOLD_LO:  if (phase_done) state_next = WAIT;
      WAIT:     if (phase_done) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Counter restarts on every state change and stays parked at 0 in IDLE,
  // so the first cycle of each phase always sees count 0.
  assign phase_load = (state_next != state) || (state == IDLE);

  lcd_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk   (Clock),
    .rst   (Reset),
    .load  (phase_load),
    .limit (phase_len),
    .done  (phase_done)
  );

  // LCD pins decoded from state so reset drops E without waiting for a clock
  always_comb begin
    oLcdE    = 1'b0;
    oLcdRs   = 1'b0;
    oLcdData = '0;
    oBusy    = 1'b0;
    if (state != IDLE) begin
      oBusy  = 1'b1;
      oLcdRs = rs_q;
      oLcdE  = (state == PULSE_HI) || (state == PULSE_LO);
      if ((state == SETUP_HI) || (state == PULSE_HI) || (state == HOLD_HI)) begin
        oLcdData = data_q[7:4];
      end else begin
        oLcdData = data_q[3:0];
      end
    end
  end

  assign oLcdRw = 1'b0;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
module tb_lcd_write_arbiter;

  localparam int S    = 2;
  localparam int P    = 4;
  localparam int H    = 2;
  localparam int CW   = 10;
  localparam int LW   = 50;
  localparam int HALF = S + P + H;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iReq0Valid = 1'b0, iReq0Rs = 1'b0;
  logic [7:0] iReq0Data = 8'h00;
  logic       iReq1Valid = 1'b0, iReq1Rs = 1'b0;
  logic [7:0] iReq1Data = 8'h00;
  logic       oReq0Ready, oReq1Ready, oLcdRs, oLcdRw, oLcdE, oBusy;
  logic [3:0] oLcdData;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  lcd_write_arbiter #(
    .SETUP_CYC     (S),
    .PULSE_CYC     (P),
    .HOLD_CYC      (H),
    .CMD_WAIT_CYC  (CW),
    .LONG_WAIT_CYC (LW)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iReq0Valid (iReq0Valid),
    .iReq0Rs    (iReq0Rs),
    .iReq0Data  (iReq0Data),
    .iReq1Valid (iReq1Valid),
    .iReq1Rs    (iReq1Rs),
    .iReq1Data  (iReq1Data),
    .oReq0Ready (oReq0Ready),
    .oReq1Ready (oReq1Ready),
    .oLcdRs     (oLcdRs),
    .oLcdRw     (oLcdRw),
    .oLcdE      (oLcdE),
    .oLcdData   (oLcdData),
    .oBusy      (oBusy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: m_e counts cycles since acceptance (-1 = idle)
  int         m_e     = -1;
  int         m_total = 0;
  int         m_last  = 1;   // last accepted requester; reset behaves as if 1
  logic [7:0] m_byte  = 8'h00;
  logic       m_rs    = 1'b0;

  function automatic int wait_len(input logic rs, input logic [7:0] b);
    return (rs == 1'b0 && b < 8'h04 && b != 8'h00) ? LW : CW;
  endfunction

  function automatic logic model_grant(input int who);
    if (Reset || m_e >= 0) return 1'b0;
    if (who == 0) return iReq0Valid && (!iReq1Valid || m_last == 1);
    return iReq1Valid && (!iReq0Valid || m_last == 0);
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_e = -1; m_last = 1; m_byte = 8'h00; m_rs = 1'b0;
    end else if (m_e < 0) begin
      if (model_grant(0) || model_grant(1)) begin
        if (model_grant(0)) begin
          m_byte = iReq0Data; m_rs = iReq0Rs; m_last = 0;
        end else begin
          m_byte = iReq1Data; m_rs = iReq1Rs; m_last = 1;
        end
        m_total = 2 * HALF + wait_len(m_rs, m_byte);
        m_e     = 0;
      end
    end else begin
      m_e++;
      if (m_e == m_total) m_e = -1;
    end
  end

  logic       x_busy, x_e, x_rs;
  logic [3:0] x_data;
  int         x_pos;

  always @(negedge Clock) begin
    x_busy = 1'b0; x_e = 1'b0; x_rs = 1'b0; x_data = 4'h0;
    if (m_e >= 0) begin
      x_busy = 1'b1;
      x_rs   = m_rs;
      x_data = (m_e < HALF) ? 4'(m_byte / 16) : 4'(m_byte % 16);
      x_pos  = (m_e < HALF) ? m_e : m_e - HALF;
      x_e    = (m_e < 2 * HALF) && (x_pos >= S) && (x_pos < S + P);
    end
    check("ready0", 8'(oReq0Ready), 8'(model_grant(0)));
    check("ready1", 8'(oReq1Ready), 8'(model_grant(1)));
    check("both_ready", 8'(oReq0Ready & oReq1Ready), 8'h00);
    check("lcd_e", 8'(oLcdE), 8'(x_e));
    check("lcd_rs", 8'(oLcdRs), 8'(x_rs));
    check("lcd_rw", 8'(oLcdRw), 8'h00);
    check("lcd_data", 8'(oLcdData), 8'(x_data));
    check("busy", 8'(oBusy), 8'(x_busy));
  end

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!oBusy) return;
      next_cycle();
    end
    check("idle_timeout", 8'(oBusy), 8'h00);
  endtask

  // Returns at a negedge where a Ready is high; who = -1 on timeout
  task automatic wait_ready(output int who, output int at_cyc);
    who = -1; at_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (oReq0Ready || oReq1Ready) begin
        who    = oReq1Ready ? 1 : 0;
        at_cyc = cyc;
        return;
      end
    end
  endtask

  task automatic measure(output int busy, output int ecnt, output logic [3:0] first_nib,
                         output logic [3:0] last_nib, output logic rs_seen);
    busy = 0; ecnt = 0; first_nib = 4'h0; last_nib = 4'h0; rs_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clock);
      if (!oBusy) return;
      busy++;
      if (oLcdE) begin
        if (ecnt == 0) first_nib = oLcdData;
        last_nib = oLcdData;
        rs_seen  = oLcdRs;
        ecnt++;
      end
    end
  endtask

  int         who, t1, t2, busy, ecnt;
  logic [3:0] fn, ln;
  logic       rs_s;

  initial begin
    #1 Reset = 1'b1;
    #1;
    check("rst_busy", 8'(oBusy), 8'h00);
    check("rst_e", 8'(oLcdE), 8'h00);
    check("rst_rs", 8'(oLcdRs), 8'h00);
    check("rst_data", 8'(oLcdData), 8'h00);
    next_cycle(); next_cycle();
    Reset = 1'b0;
    next_cycle();

    // Single data write from requester 0
    iReq0Valid = 1'b1; iReq0Rs = 1'b1; iReq0Data = 8'h41;
    wait_ready(who, t1);
    check("single_who", 8'(who), 8'h00);
    next_cycle();
    iReq0Valid = 1'b0;
    measure(busy, ecnt, fn, ln, rs_s);
    check("single_busy", 8'(busy), 8'd26);
    check("single_ecnt", 8'(ecnt), 8'd8);
    check("single_hi_nib", 8'(fn), 8'h04);
    check("single_lo_nib", 8'(ln), 8'h01);
    check("single_rs", 8'(rs_s), 8'h01);

    // Clear-display command from requester 1
    next_cycle();
    wait_idle();
    iReq1Valid = 1'b1; iReq1Rs = 1'b0; iReq1Data = 8'h01;
    wait_ready(who, t1);
    check("clear_who", 8'(who), 8'h01);
    next_cycle();
    iReq1Valid = 1'b0;
    measure(busy, ecnt, fn, ln, rs_s);
    check("clear_busy", 8'(busy), 8'd66);
    check("clear_hi_nib", 8'(fn), 8'h00);
    check("clear_lo_nib", 8'(ln), 8'h01);
    check("clear_rs", 8'(rs_s), 8'h00);

    // Contention: both valid continuously
    next_cycle();
    wait_idle();
    iReq0Valid = 1'b1; iReq0Rs = 1'b1; iReq0Data = 8'hAA;
    iReq1Valid = 1'b1; iReq1Rs = 1'b1; iReq1Data = 8'h55;
    for (int k = 0; k < 4; k++) begin
      wait_ready(who, t1);
      check("contend_who", 8'(who), 8'(k % 2));
      next_cycle();
    end
    iReq0Valid = 1'b0; iReq1Valid = 1'b0;

    // Reset in the middle of the low-nibble E pulse
    wait_idle();
    iReq0Valid = 1'b1; iReq0Rs = 1'b1; iReq0Data = 8'h41;
    wait_ready(who, t1);
    check("rst_test_who", 8'(who), 8'h00);
    next_cycle();
    iReq0Valid = 1'b0;
    for (int i = 0; i < HALF + S + 1; i++) next_cycle();
    #2;
    check("pulse_lo_e", 8'(oLcdE), 8'h01);
    Reset = 1'b1;
    #1;
    check("async_rst_e", 8'(oLcdE), 8'h00);
    check("async_rst_busy", 8'(oBusy), 8'h00);
    next_cycle(); next_cycle();
    Reset = 1'b0;
    iReq0Valid = 1'b1; iReq0Rs = 1'b1; iReq0Data = 8'h12;
    iReq1Valid = 1'b1; iReq1Rs = 1'b1; iReq1Data = 8'h34;
    wait_ready(who, t1);
    check("post_rst_who", 8'(who), 8'h00);
    next_cycle();
    iReq0Valid = 1'b0; iReq1Valid = 1'b0;

    // Back-to-back from requester 0: next accept in the first IDLE cycle
    wait_idle();
    iReq0Valid = 1'b1; iReq0Rs = 1'b0; iReq0Data = 8'h30;
    wait_ready(who, t1);
    check("b2b_first", 8'(who), 8'h00);
    next_cycle();
    wait_ready(who, t2);
    check("b2b_second", 8'(who), 8'h00);
    check("b2b_gap", 8'(t2 - t1), 8'(2 * HALF + CW + 1));
    next_cycle();
    iReq0Valid = 1'b0;
    wait_idle();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
